// File: rtl/piso_register.sv
// Parallel-in, serial-out unload register: captures a word on an accepted load
// and drains it one bit per valid/ready transfer, pulsing done after the last bit.
module piso_register #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d, sreg_sh;
  logic [CW-1:0]    cnt, cnt_d;
  logic             out_bit;

  // Output end and shift direction are fixed at elaboration.
  generate
    if (MSB_FIRST) begin : g_msb
      assign out_bit = sreg[WIDTH-1];
      assign sreg_sh = {sreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign out_bit = sreg[0];
      assign sreg_sh = {1'b0, sreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      sreg  <= sreg_d;
      cnt   <= cnt_d;
    end
  end

  // Outputs depend only on registered state, never on the inputs.
  always_comb begin
    state_d   = state;
    sreg_d    = sreg;
    cnt_d     = cnt;
    ready     = 1'b0;
    busy      = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (load) begin
          sreg_d  = data_in;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_out   = out_bit;
        if (ser_ready) begin
          sreg_d = sreg_sh;
          cnt_d  = cnt - 1'b1;
          if (cnt == CW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (load) begin
          sreg_d  = data_in;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_register.sv
// Bench for piso_register: an MSB-first and an LSB-first instance share stimulus;
// expected bit order and latency come from the word value and the stall schedule.
module tb_piso_register;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, load, ser_ready;
  logic [W-1:0] data_in;
  logic         rdy_m, so_m, sv_m, bsy_m, dn_m;
  logic         rdy_l, so_l, sv_l, bsy_l, dn_l;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  piso_register #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .ready(rdy_m),
    .ser_out(so_m), .ser_valid(sv_m), .ser_ready(ser_ready), .busy(bsy_m), .done(dn_m)
  );

  piso_register #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .ready(rdy_l),
    .ser_out(so_l), .ser_valid(sv_l), .ser_ready(ser_ready), .busy(bsy_l), .done(dn_l)
  );

  typedef struct {
    logic [W-1:0] d;
    int           sa;     // transfers completed before the stall starts (W = none)
    int           sl;     // stall length in cycles
    bit           bl;     // pulse load with other data mid-shift
    bit           chain;  // next word is loaded in the DONE cycle
    logic [W-1:0] em;     // MSB-first transmit order, first bit at [W-1]
    logic [W-1:0] el;     // LSB-first transmit order, first bit at [W-1]
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_ready"},     {rdy_m, rdy_l}, 2'b11);
    chk({tag, "_busy"},      {bsy_m, bsy_l}, 2'b00);
    chk({tag, "_ser_valid"}, {sv_m, sv_l},   2'b00);
    chk({tag, "_ser_out"},   {so_m, so_l},   2'b00);
    chk({tag, "_done"},      {dn_m, dn_l},   2'b00);
  endtask

  // Entered at the negedge where load was raised; returns at the DONE-cycle negedge.
  task automatic drain(input logic [W-1:0] em, input logic [W-1:0] el, input int sa,
                       input int sl, input bit bl, input logic [W-1:0] d);
    int b   = 0;
    int st  = 0;
    int cyc = 0;
    int exp_lat;
    exp_lat = W + 1 + ((sa < W) ? sl : 0);
    @(negedge clk);
    load    = 1'b0;
    data_in = $urandom;
    while (b < W) begin
      cyc++;
      if (cyc > 64) begin
        nchk++;
        nerr++;
        $display("FAIL drain_timeout: got %0d transfers expected %0d", b, W);
        return;
      end
      chk("shift_ser_valid", {sv_m, sv_l},   2'b11);
      chk("shift_busy",      {bsy_m, bsy_l}, 2'b11);
      chk("shift_ready",     {rdy_m, rdy_l}, 2'b00);
      chk("shift_done",      {dn_m, dn_l},   2'b00);
      chk("ser_out_msb",     so_m, em[W-1-b]);
      chk("ser_out_lsb",     so_l, el[W-1-b]);
      ser_ready = !(b == sa && st < sl);
      if (ser_ready) b++; else st++;
      if (bl && b == 3) begin
        load    = 1'b1;
        data_in = ~d;
      end else begin
        load    = 1'b0;
        data_in = $urandom;
      end
      @(negedge clk);
    end
    load = 1'b0;
    chk("done_pulse",     {dn_m, dn_l},   2'b11);
    chk("done_ready",     {rdy_m, rdy_l}, 2'b11);
    chk("done_busy",      {bsy_m, bsy_l}, 2'b00);
    chk("done_ser_valid", {sv_m, sv_l},   2'b00);
    chk("done_ser_out",   {so_m, so_l},   2'b00);
    chk("latency",        cyc + 1,        exp_lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[5];
    tbl[0] = '{8'hA5, W, 0, 1'b0, 1'b0, 8'hA5, 8'hA5};
    tbl[1] = '{8'hC3, 2, 3, 1'b0, 1'b0, 8'hC3, 8'hC3};
    tbl[2] = '{8'h0F, W, 0, 1'b1, 1'b0, 8'h0F, 8'hF0};
    tbl[3] = '{8'h01, W, 0, 1'b0, 1'b1, 8'h01, 8'h80};
    tbl[4] = '{8'h80, W, 0, 1'b0, 1'b0, 8'h80, 8'h01};

    rst = 1'b1; load = 1'b0; ser_ready = 1'b0; data_in = '0;
    @(negedge clk);
    load = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    check_idle("reset");
    @(negedge clk);
    check_idle("reset_nocapture");

    for (int i = 0; i < 5; i++) begin
      load = 1'b1;
      data_in = tbl[i].d;
      drain(tbl[i].em, tbl[i].el, tbl[i].sa, tbl[i].sl, tbl[i].bl, tbl[i].d);
      if (!tbl[i].chain) begin
        @(negedge clk);
        check_idle("vec_idle");
      end
    end

    // Abort mid-word, then a clean word afterwards.
    load = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    load = 1'b0; ser_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("abort_pre_valid", {sv_m, sv_l}, 2'b11);
      chk("abort_pre_bit",   {so_m, so_l}, 2'b11);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("abort");
    @(negedge clk);
    check_idle("abort_nodone");
    load = 1'b1; data_in = 8'h81;
    drain(8'h81, 8'h81, W, 0, 1'b0, 8'h81);
    @(negedge clk);
    check_idle("post_abort_idle");

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] d;
      int sa, sl;
      bit bl, chain;
      d     = $urandom;
      sa    = $urandom_range(0, W);
      sl    = $urandom_range(0, 3);
      bl    = 1'($urandom_range(0, 1));
      chain = 1'($urandom_range(0, 1));
      load = 1'b1;
      data_in = d;
      drain(d, rev(d), sa, sl, bl, d);
      if (!chain) begin
        @(negedge clk);
        check_idle("rand_idle");
      end
    end
    load = 1'b0;
    @(negedge clk);
    check_idle("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
